// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared FSM encodings, funct3 constants and load/store helper functions
package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Only the encodings the core actually emits are accepted.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        end else begin
            ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        end
        return ok;
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 1x word (11 is illegal anyway).
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow stores replicate the datum so any enabled lane carries it.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory bus between the load/store unit and memory
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - combinational byte/half lane select with sign or zero extension
module load_ext
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // pick the addressed lane, then extend according to the load type
    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        case (funct3)
            LB:      data = {{24{byte_lane[7]}}, byte_lane};
            LH:      data = {{16{half_lane[15]}}, half_lane};
            LBU:     data = {24'h000000, byte_lane};
            LHU:     data = {16'h0000, half_lane};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit with bus handshake FSM; optional MEM_TIMEOUT_EN ack timeout
module mem_access
    import rv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] Rd2,
    input  logic [2:0]       mem_cntr,
    input  logic             mem_rd,
    input  logic             mem_wr,
    output logic             stall,
    output logic [WIDTH-1:0] load_data,
    output logic             load_valid,
    output logic             fault,
    mem_access_if.master     dmem
);
    if (WIDTH != 32) begin : g_bad_width
        $error("mem_access: only WIDTH=32 is supported");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT must fit the 8-bit wait counter");
    end

    mem_state_t  state;
    mem_state_t  state_nxt;
    logic        access;
    logic        is_store;
    logic        legal;
    logic        misaligned;
    logic        issue;
    logic        reject;
    logic        timed_out;
    logic [2:0]  txn_f3;
    logic [1:0]  txn_off;
    logic [31:0] ext_data;

    // classify the access presented by the execute stage
    always_comb begin
        access     = mem_rd | mem_wr;
        is_store   = mem_wr;
        legal      = access_legal(is_store, mem_cntr);
        misaligned = access_misaligned(mem_cntr[1:0], alu_result[1:0]);
        issue      = (state == ST_IDLE) && access && legal && !misaligned;
        reject     = (state == ST_IDLE) && access && !(legal && !misaligned);
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign timed_out = (state == ST_WAIT) && !dmem.dmem_ack && (tmo_cnt == 8'(TIMEOUT - 1));

    // count WAIT cycles without ack; restarts with every new bus request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
        end else if (issue) begin
            tmo_cnt <= 8'd0;
        end else if (state == ST_WAIT && !dmem.dmem_ack) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and stall; stall is forced low while reset is asserted
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_nxt = ST_WAIT;
                    stall     = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (dmem.dmem_ack || timed_out) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // bus request registers, load result capture and one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'h0;
            dmem.dmem_wdata <= 32'h0;
            dmem.dmem_be    <= 4'h0;
            txn_f3          <= 3'b000;
            txn_off         <= 2'b00;
            load_data       <= '0;
            load_valid      <= 1'b0;
            fault           <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= is_store;
                        dmem.dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem.dmem_be    <= is_store ? store_be(mem_cntr[1:0], alu_result[1:0]) : 4'b1111;
                        dmem.dmem_wdata <= is_store ? store_wdata(mem_cntr[1:0], Rd2) : 32'h0;
                        txn_f3          <= mem_cntr;
                        txn_off         <= alu_result[1:0];
                    end else if (reject) begin
                        fault <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_we) begin
                            load_data  <= ext_data;
                            load_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        dmem.dmem_req <= 1'b0;
                        fault         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    load_ext u_load_ext (
        .funct3 (txn_f3),
        .offset (txn_off),
        .rdata  (dmem.dmem_rdata),
        .data   (ext_data)
    );
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed table-driven bench for mem_access
module tb_mem_access;
    import rv_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic [31:0] rdata;
        int          ack_wait;
        logic        exp_fault;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_ld;
        logic        exp_lv;
    } vec_t;

    localparam int NV = 21;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result;
    logic [31:0] rd2_in;
    logic [2:0]  mem_cntr;
    logic        mem_rd;
    logic        mem_wr;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NV];

    mem_access_if bus ();

    mem_access #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_result (alu_result),
        .Rd2        (rd2_in),
        .mem_cntr   (mem_cntr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .dmem       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rd2,
                                input logic [31:0] rdata, input int ack_wait,
                                input logic exp_fault, input logic [31:0] exp_addr,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input logic exp_we, input logic [31:0] exp_ld,
                                input logic exp_lv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
        v.ack_wait = ack_wait; v.exp_fault = exp_fault; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_we = exp_we;
        v.exp_ld = exp_ld; v.exp_lv = exp_lv;
        return v;
    endfunction

    task automatic drop_inputs();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        mem_cntr = 3'b000;
        alu_result = 32'h0;
        rd2_in = 32'h0;
    endtask

    // Entered #1 after a rising edge with inputs idle; leaves in the same phase.
    task automatic run_vec(input int idx, input vec_t v);
        int stalls;
        mem_rd = v.rd;
        mem_wr = v.wr;
        mem_cntr = v.f3;
        alu_result = v.addr;
        rd2_in = v.rd2;
        @(negedge clk);
        if (v.exp_fault) begin
            chk($sformatf("v%0d_stall_reject", idx), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            drop_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_fault", idx), {31'b0, fault}, 32'd1);
            chk($sformatf("v%0d_req_none", idx), {31'b0, bus.dmem_req}, 32'd0);
            chk($sformatf("v%0d_ld_hold", idx), load_data, v.exp_ld);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_fault_pulse", idx), {31'b0, fault}, 32'd0);
            chk($sformatf("v%0d_req_none2", idx), {31'b0, bus.dmem_req}, 32'd0);
            @(posedge clk); #1;
        end else begin
            stalls = stall ? 1 : 0;
            for (int n = 0; n <= v.ack_wait; n++) begin
                @(posedge clk); #1;
                bus.dmem_ack = (n == v.ack_wait);
                bus.dmem_rdata = (n == v.ack_wait) ? v.rdata : ~v.rdata;
                @(negedge clk);
                if (stall) stalls++;
                chk($sformatf("v%0d_req", idx), {31'b0, bus.dmem_req}, 32'd1);
                chk($sformatf("v%0d_addr", idx), bus.dmem_addr, v.exp_addr);
                chk($sformatf("v%0d_be", idx), {28'b0, bus.dmem_be}, {28'b0, v.exp_be});
                chk($sformatf("v%0d_we", idx), {31'b0, bus.dmem_we}, {31'b0, v.exp_we});
                if (v.exp_we) chk($sformatf("v%0d_wdata", idx), bus.dmem_wdata, v.exp_wdata);
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = ~v.rdata;
            @(negedge clk);
            chk($sformatf("v%0d_done_stall", idx), {31'b0, stall}, 32'd0);
            chk($sformatf("v%0d_done_req", idx), {31'b0, bus.dmem_req}, 32'd0);
            chk($sformatf("v%0d_load_valid", idx), {31'b0, load_valid}, {31'b0, v.exp_lv});
            chk($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
            chk($sformatf("v%0d_done_fault", idx), {31'b0, fault}, 32'd0);
            chk($sformatf("v%0d_stall_cycles", idx), stalls, 2 + v.ack_wait);
            @(posedge clk); #1;
            drop_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_lv_pulse", idx), {31'b0, load_valid}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        //            rd  wr  f3      addr          rd2           rdata         ack flt e_addr        e_be     e_wdata       we  e_ld          lv
        vecs[0]  = mk(1, 0, LW,     32'h100,      32'h0,        32'hDEADBEEF, 2, 0, 32'h100,      4'b1111, 32'h0,        0, 32'hDEADBEEF, 1);
        vecs[1]  = mk(1, 0, LB,     32'h103,      32'h0,        32'h80FFFFFF, 0, 0, 32'h100,      4'b1111, 32'h0,        0, 32'hFFFFFF80, 1);
        vecs[2]  = mk(1, 0, LBU,    32'h103,      32'h0,        32'h80FFFFFF, 1, 0, 32'h100,      4'b1111, 32'h0,        0, 32'h00000080, 1);
        vecs[3]  = mk(0, 1, SH,     32'h102,      32'h1234ABCD, 32'h0,        1, 0, 32'h100,      4'b1100, 32'hABCDABCD, 1, 32'h00000080, 0);
        vecs[4]  = mk(1, 0, LW,     32'h101,      32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h00000080, 0);
        vecs[5]  = mk(1, 0, LH,     32'h202,      32'h0,        32'h80017FFF, 0, 0, 32'h200,      4'b1111, 32'h0,        0, 32'hFFFF8001, 1);
        vecs[6]  = mk(1, 0, LHU,    32'h200,      32'h0,        32'h8001F00F, 3, 0, 32'h200,      4'b1111, 32'h0,        0, 32'h0000F00F, 1);
        vecs[7]  = mk(0, 1, SB,     32'h31,       32'hCAFEBA5E, 32'h0,        0, 0, 32'h30,       4'b0010, 32'h5E5E5E5E, 1, 32'h0000F00F, 0);
        vecs[8]  = mk(0, 1, SW,     32'h44,       32'h01234567, 32'h0,        1, 0, 32'h44,       4'b1111, 32'h01234567, 1, 32'h0000F00F, 0);
        vecs[9]  = mk(1, 0, LH,     32'h201,      32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0000F00F, 0);
        vecs[10] = mk(1, 0, 3'b011, 32'h100,      32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0000F00F, 0);
        vecs[11] = mk(0, 1, 3'b100, 32'h100,      32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0000F00F, 0);
        vecs[12] = mk(1, 1, SW,     32'h48,       32'hA5A50F0F, 32'h0,        0, 0, 32'h48,       4'b1111, 32'hA5A50F0F, 1, 32'h0000F00F, 0);
        vecs[13] = mk(1, 0, LB,     32'h101,      32'h0,        32'h12345678, 0, 0, 32'h100,      4'b1111, 32'h0,        0, 32'h00000056, 1);
        vecs[14] = mk(0, 1, SB,     32'h3,        32'h000000FF, 32'h0,        0, 0, 32'h0,        4'b1000, 32'hFFFFFFFF, 1, 32'h00000056, 0);
        vecs[15] = mk(1, 0, LW,     32'hFFFFFFFC, 32'h0,        32'h0,        1, 0, 32'hFFFFFFFC, 4'b1111, 32'h0,        0, 32'h00000000, 1);
        vecs[16] = mk(1, 0, LBU,    32'h102,      32'h0,        32'h00AB0000, 0, 0, 32'h100,      4'b1111, 32'h0,        0, 32'h000000AB, 1);
        vecs[17] = mk(0, 1, SH,     32'h100,      32'h5555BEEF, 32'h0,        0, 0, 32'h100,      4'b0011, 32'hBEEFBEEF, 1, 32'h000000AB, 0);
        vecs[18] = mk(1, 0, LH,     32'h100,      32'h0,        32'h7FFF8000, 0, 0, 32'h100,      4'b1111, 32'h0,        0, 32'hFFFF8000, 1);
        vecs[19] = mk(1, 0, 3'b110, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'hFFFF8000, 0);
        vecs[20] = mk(0, 1, 3'b111, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 32'hFFFF8000, 0);

        rst_n = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        mem_rd = 1'b1;
        mem_wr = 1'b0;
        mem_cntr = LW;
        alu_result = 32'h100;
        rd2_in = 32'h0;

        // reset state, with a legal load presented to prove stall stays low
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_we", {31'b0, bus.dmem_we}, 32'd0);
        chk("rst_be", {28'b0, bus.dmem_be}, 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'h0);
        chk("rst_wdata", bus.dmem_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        drop_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // ack while idle must not produce a result or a request
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h11111111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle_ack_req", {31'b0, bus.dmem_req}, 32'd0);
            chk("idle_ack_lv", {31'b0, load_valid}, 32'd0);
            chk("idle_ack_ld", load_data, 32'hFFFF8000);
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b0;

        // a load that is never acknowledged
        mem_rd = 1'b1;
        mem_cntr = LW;
        alu_result = 32'h100;
        @(negedge clk);
        chk("noack_issue_stall", {31'b0, stall}, 32'd1);
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("tmo_c%0d_req", c), {31'b0, bus.dmem_req}, 32'd1);
            chk($sformatf("tmo_c%0d_fault", c), {31'b0, fault}, 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_c5_fault", {31'b0, fault}, 32'd1);
        chk("tmo_c5_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("tmo_c5_stall", {31'b0, stall}, 32'd0);
        chk("tmo_c5_lv", {31'b0, load_valid}, 32'd0);
        @(posedge clk); #1;
        drop_inputs();
        @(negedge clk);
        chk("tmo_c6_fault", {31'b0, fault}, 32'd0);
        @(posedge clk); #1;
`else
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("persist_req", {31'b0, bus.dmem_req}, 32'd1);
        chk("persist_stall", {31'b0, stall}, 32'd1);
        chk("persist_fault", {31'b0, fault}, 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("persist_done_ld", load_data, 32'h0BADF00D);
        @(posedge clk); #1;
        drop_inputs();
        @(posedge clk); #1;
`endif

        // reset in the middle of WAIT abandons the access
        mem_rd = 1'b1;
        mem_cntr = LW;
        alu_result = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_req_before", {31'b0, bus.dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        chk("midrst_ld", load_data, 32'h0);
        chk("midrst_be", {28'b0, bus.dmem_be}, 32'd0);
        drop_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_retry", {31'b0, bus.dmem_req}, 32'd0);
            chk("midrst_idle_stall", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
